// File: rtl/ts_mux_pkg.sv
// rtl/ts_mux_pkg.sv - shared state encoding, widths and helpers for the TS packet arbiter
package ts_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_CNT_W = 16;

   // Ceiling log2 that never returns less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/ts_rr_pick.sv
// rtl/ts_rr_pick.sv - combinational round-robin / fixed-priority winner picker
module ts_rr_pick #(
   parameter int NUM_CHANS  = 4,
   parameter int CHAN_IDX_W = 2
) (
   input  logic [NUM_CHANS-1:0]  elig,
   input  logic [CHAN_IDX_W-1:0] rr_ptr,
   input  logic                  arb_mode,
   output logic [CHAN_IDX_W-1:0] winner,
   output logic                  any_valid
);

   logic [2*NUM_CHANS-1:0] doubled;
   logic [NUM_CHANS-1:0]   rotated;
   logic [NUM_CHANS-1:0]   search;
   int                     first;
   int                     sum;

   // Rotating the doubled vector puts rr_ptr at bit 0, so one lowest-bit
   // encoder serves both modes.
   always_comb begin
      doubled = {elig, elig};
      rotated = doubled[rr_ptr +: NUM_CHANS];
      search  = arb_mode ? elig : rotated;
      first   = 0;
      for (int i = NUM_CHANS - 1; i >= 0; i--) begin
         if (search[i]) first = i;
      end
      sum = arb_mode ? first : first + int'(rr_ptr);
      if (sum >= NUM_CHANS) sum = sum - NUM_CHANS;
      winner    = CHAN_IDX_W'(sum);
      any_valid = |elig;
   end

endmodule

// File: rtl/ts_packet_arbiter.sv
// rtl/ts_packet_arbiter.sv - N-channel TS packet multiplexer with RR/priority arbitration and grant watchdog
module ts_packet_arbiter
   import ts_mux_pkg::*;
#(
   parameter int NUM_CHANS        = 4,
   parameter int DATA_W           = 32,
   parameter int MAX_GRANT_CYCLES = 1024,
   localparam int CHAN_IDX_W      = clog2_min1(NUM_CHANS)
) (
   input  logic                          payload_clk,
   input  logic                          payload_rst,
   input  logic                          arb_mode,
   input  logic [NUM_CHANS-1:0]          chan_enable,
   input  logic [NUM_CHANS-1:0]          payload_req_in,
   output logic [NUM_CHANS-1:0]          chan_out_req,
   input  logic [NUM_CHANS-1:0]          chan_out_ack,
   input  logic [NUM_CHANS*DATA_W-1:0]   payload_in_data,
   input  logic [NUM_CHANS-1:0]          payload_in_valid,
   input  logic [NUM_CHANS-1:0]          payload_in_start,
   input  logic [NUM_CHANS-1:0]          payload_in_end,
   output logic [DATA_W-1:0]             payload_out_data,
   output logic                          payload_out_valid,
   output logic                          payload_out_start,
   output logic                          payload_out_end,
   output logic [CHAN_IDX_W-1:0]         grant_chan,
   output logic                          busy,
   output logic                          timeout_pulse,
   output logic [TIMEOUT_CNT_W-1:0]      timeout_count
);

   localparam int WD_W = clog2_min1(MAX_GRANT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST =
      WD_W'((MAX_GRANT_CYCLES > 0) ? MAX_GRANT_CYCLES - 1 : 0);
   localparam bit WD_ON = (MAX_GRANT_CYCLES != 0);

   arb_state_t              state, state_next;
   logic [CHAN_IDX_W-1:0]   rr_ptr;
   logic [CHAN_IDX_W-1:0]   winner;
   logic                    any_valid;
   logic [WD_W-1:0]         watchdog;
   logic [NUM_CHANS-1:0]    elig;
   logic                    ack_hit;
   logic                    expire;
   logic [DATA_W-1:0]       chan_data [NUM_CHANS];

   for (genvar g = 0; g < NUM_CHANS; g++) begin : g_unpack
      assign chan_data[g] = payload_in_data[DATA_W*g +: DATA_W];
   end

   assign elig    = payload_req_in & chan_enable;
   assign ack_hit = chan_out_ack[grant_chan];
   assign expire  = WD_ON && (watchdog == WD_LAST);

   ts_rr_pick #(
      .NUM_CHANS  (NUM_CHANS),
      .CHAN_IDX_W (CHAN_IDX_W)
   ) u_pick (
      .elig      (elig),
      .rr_ptr    (rr_ptr),
      .arb_mode  (arb_mode),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge payload_clk) begin
      if (payload_rst) state <= ST_IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next   = state;
      chan_out_req = '0;
      busy         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_valid) state_next = ST_GRANT;
         end
         ST_GRANT: begin
            chan_out_req[grant_chan] = 1'b1;
            busy                     = 1'b1;
            if (ack_hit || expire) state_next = ST_RELEASE;
         end
         ST_RELEASE: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge payload_clk) begin
      if (payload_rst) begin
         grant_chan        <= '0;
         rr_ptr            <= '0;
         watchdog          <= '0;
         timeout_pulse     <= 1'b0;
         timeout_count     <= '0;
         payload_out_data  <= '0;
         payload_out_valid <= 1'b0;
         payload_out_start <= 1'b0;
         payload_out_end   <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_valid) grant_chan <= winner;
            end
            ST_GRANT: begin
               watchdog <= watchdog + 1'b1;
               // An ack landing on the expiry cycle is a normal completion.
               if (!ack_hit && expire) begin
                  timeout_pulse <= 1'b1;
                  if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
               end
            end
            ST_RELEASE: begin
               watchdog <= '0;
               if (!arb_mode)
                  rr_ptr <= (grant_chan == CHAN_IDX_W'(NUM_CHANS - 1)) ? '0 : grant_chan + 1'b1;
            end
            default: ;
         endcase

         if (state == ST_GRANT) begin
            payload_out_data  <= chan_data[grant_chan];
            payload_out_valid <= payload_in_valid[grant_chan];
            payload_out_start <= payload_in_start[grant_chan];
            payload_out_end   <= payload_in_end[grant_chan];
         end else begin
            payload_out_data  <= '0;
            payload_out_valid <= 1'b0;
            payload_out_start <= 1'b0;
            payload_out_end   <= 1'b0;
         end
      end
   end

endmodule
